// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the registered ALU.
// Opcode values match the legacy combinational ALU so the control decoder is unchanged.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MULTU = 4'b0101;
    localparam logic [3:0] OP_DIVU  = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1100;
    localparam logic [3:0] OP_JR    = 4'b1101;
    localparam logic [3:0] OP_SLL   = 4'b1110;
    localparam logic [3:0] OP_SRA   = 4'b1111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per step.
// Latency: WIDTH step cycles after load; last flags the final step.
// Backpressure: none; the parent must not load while stepping.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic             div_mode,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    assign last = step && (cnt == CNT_LAST);

    // Partial remainder is always below the divisor, so the W+1-bit difference's
    // top bit is a clean borrow flag.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q & {WIDTH{lo_q[0]}}};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_mode) begin
            hi_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            hi_q     <= '0;
            lo_q     <= is_div ? a : b;
            opnd_q   <= is_div ? b : a;
            cnt      <= '0;
            div_mode <= is_div;
        end else if (step) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            cnt  <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; MULTU/DIVU iterate and write HI/LO.
// Latency: 1 edge for single-cycle ops and DIVU by zero, WIDTH+1 edges for MULTU/DIVU.
// Backpressure: start is ignored while busy; start alongside done is accepted.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic [WIDTH-1:0]   HI,
    output logic [WIDTH-1:0]   LO,
    output logic               DivByZero
);

    logic [0:0]       state;
    logic [WIDTH-1:0] alu_comb;
    logic [WIDTH-1:0] jr_val;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic             it_last;
    logic             it_div;
    logic             is_multi;
    logic             it_load;

    assign busy     = (state == ST_RUN);
    assign is_multi = (ALUOperation == OP_MULTU) ||
                      ((ALUOperation == OP_DIVU) && (B != '0));
    assign it_load  = start && (state == ST_IDLE) && is_multi;

    // JR field sits at bits 25:21; narrower builds see only what exists.
    if (WIDTH >= 26) begin : g_jr_full
        assign jr_val = WIDTH'(A[25:21]);
    end else if (WIDTH > 21) begin : g_jr_part
        assign jr_val = WIDTH'(A[WIDTH-1:21]);
    end else begin : g_jr_none
        assign jr_val = '0;
    end

    always_comb begin
        alu_comb = '0;
        case (ALUOperation)
            OP_AND:  alu_comb = A & B;
            OP_OR:   alu_comb = A | B;
            OP_NOR:  alu_comb = ~(A | B);
            OP_ADD:  alu_comb = A + B;
            OP_SUB:  alu_comb = A - B;
            OP_SLL:  alu_comb = B << shamt;
            OP_SRL:  alu_comb = B >> shamt;
            OP_SRA:  alu_comb = WIDTH'($signed(B) >>> shamt);
            OP_SLT:  alu_comb = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: alu_comb = WIDTH'(A < B);
            OP_JR:   alu_comb = jr_val;
            default: alu_comb = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (it_load),
        .step     (busy),
        .is_div   (ALUOperation == OP_DIVU),
        .a        (A),
        .b        (B),
        .last     (it_last),
        .div_mode (it_div),
        .hi_nxt   (it_hi),
        .lo_nxt   (it_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            HI        <= '0;
            LO        <= '0;
            DivByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    if (is_multi) begin
                        state <= ST_RUN;
                    end else if (ALUOperation == OP_DIVU) begin
                        HI        <= A;
                        LO        <= '1;
                        ALUResult <= '1;
                        Zero      <= 1'b0;
                        DivByZero <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        ALUResult <= alu_comb;
                        Zero      <= (alu_comb == '0);
                        done      <= 1'b1;
                    end
                end
            end else if (it_last) begin
                state     <= ST_IDLE;
                HI        <= it_hi;
                LO        <= it_lo;
                ALUResult <= it_lo;
                Zero      <= (it_lo == '0);
                done      <= 1'b1;
                if (it_div) begin
                    DivByZero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq at WIDTH=32 plus a WIDTH=8 instance.
module tb_alu_seq;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  s;
        logic [31:0] r;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, zero, dbz;
    logic [31:0] res, hi, lo;

    logic        start8 = 1'b0;
    logic [3:0]  op8 = 4'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  shamt8 = '0;
    logic        busy8, done8, zero8, dbz8;
    logic [7:0]  res8, hi8, lo8;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dbz = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(op),
        .A(a), .B(b), .shamt(shamt), .busy(busy), .done(done),
        .ALUResult(res), .Zero(zero), .HI(hi), .LO(lo), .DivByZero(dbz)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUOperation(op8),
        .A(a8), .B(b8), .shamt(shamt8), .busy(busy8), .done(done8),
        .ALUResult(res8), .Zero(zero8), .HI(hi8), .LO(lo8), .DivByZero(dbz8)
    );

    // Called on a falling edge; returns on the falling edge after the start edge.
    task automatic drive_start(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] s);
        start = 1'b1; op = o; a = x; b = y; shamt = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input string n, input logic [31:0] r, input int lat);
        exp_t e;
        e.name = n; e.res = r; e.hi = m_hi; e.lo = m_lo; e.dbz = m_dbz; e.lat = lat;
        sb.push_back(e);
    endtask

    // Bounded wait for done; optionally pulses a stray ADD start at cycle inj.
    task automatic wait_done(input int inj, output int cyc, output int bcnt);
        cyc = 0; bcnt = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) bcnt++;
            if (cyc == inj) begin
                start = 1'b1; op = 4'b0011; a = 32'h1234; b = 32'h1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 00000000", res); end
        vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got %b want 1", zero); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags got busy=%b done=%b dbz=%b want 0 0 0", busy, done, dbz); end
        vectors++; if (res8 !== 8'h0 || zero8 !== 1'b1 || busy8 !== 1'b0) begin
            miscompares++; $display("FAIL reset_w8 got res=%h zero=%b busy=%b want 00 1 0", res8, zero8, busy8); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        vec_t tbl[$];
        exp_t e;
        int   cyc, bc;
        tbl.push_back('{"add_ovf", 4'b0011, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000});
        tbl.push_back('{"sub_zero",4'b0100, 32'd5,        32'd5,        5'd0,  32'h0});
        tbl.push_back('{"sub_wrap",4'b0100, 32'd0,        32'd1,        5'd0,  32'hFFFFFFFF});
        tbl.push_back('{"sra",     4'b1111, 32'h0,        32'h80000000, 5'd4,  32'hF8000000});
        tbl.push_back('{"slt",     4'b0111, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1});
        tbl.push_back('{"sltu",    4'b1000, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0});
        tbl.push_back('{"unused",  4'b1001, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h0});
        tbl.push_back('{"and",     4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000});
        tbl.push_back('{"or",      4'b0001, 32'h00FF0000, 32'h0000000F, 5'd0,  32'h00FF000F});
        tbl.push_back('{"nor",     4'b0010, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF});
        tbl.push_back('{"sll",     4'b1110, 32'h0,        32'h1,        5'd31, 32'h80000000});
        tbl.push_back('{"srl",     4'b1100, 32'h0,        32'h80000000, 5'd31, 32'h1});
        tbl.push_back('{"jr",      4'b1101, 32'h03E00000, 32'h0,        5'd0,  32'h1F});
        foreach (tbl[i]) begin
            push_exp(tbl[i].name, tbl[i].r, 0);
            drive_start(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].s);
            wait_done(-1, cyc, bc);
            e = sb.pop_front();
            vectors++; if (cyc != e.lat) begin miscompares++; $display("FAIL %s_latency got %0d want %0d", e.name, cyc, e.lat); end
            vectors++; if (res !== e.res || zero !== (e.res == 32'h0)) begin
                miscompares++; $display("FAIL %s_result got %h z=%b want %h z=%b", e.name, res, zero, e.res, e.res == 32'h0); end
            vectors++; if (hi !== e.hi || lo !== e.lo || busy !== 1'b0) begin
                miscompares++; $display("FAIL %s_hold got hi=%h lo=%h busy=%b want %h %h 0", e.name, hi, lo, busy, e.hi, e.lo); end
        end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse got %b want 0", done); end
    endtask

    task automatic test_multu();
        logic [63:0] p;
        exp_t        e;
        int          cyc, bc;
        p = 64'hFFFFFFFF * 64'hFFFFFFFF;
        m_hi = p[63:32]; m_lo = p[31:0];
        push_exp("multu", p[31:0], 32);
        drive_start(4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        wait_done(5, cyc, bc);
        e = sb.pop_front();
        vectors++; if (bc != 32 || busy !== 1'b0) begin miscompares++; $display("FAIL multu_busy got %0d cycles busy_now=%b want 32 0", bc, busy); end
        vectors++; if (cyc != e.lat) begin miscompares++; $display("FAIL multu_latency got %0d want %0d", cyc, e.lat); end
        vectors++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            miscompares++; $display("FAIL multu_hilo got %h/%h want fffffffe/00000001", hi, lo); end
        vectors++; if (res !== e.res || hi !== e.hi || lo !== e.lo || dbz !== e.dbz) begin
            miscompares++; $display("FAIL multu_result got %h dbz=%b want %h dbz=%b", res, dbz, e.res, e.dbz); end
    endtask

    task automatic test_divu();
        exp_t e;
        int   cyc, bc;
        m_lo = 32'd100 / 32'd7; m_hi = 32'd100 % 32'd7; m_dbz = 1'b0;
        push_exp("divu", m_lo, 32);
        drive_start(4'b0110, 32'd100, 32'd7, 5'd0);
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        vectors++; if (cyc != e.lat || bc != 32) begin miscompares++; $display("FAIL divu_latency got %0d busy %0d want %0d 32", cyc, bc, e.lat); end
        vectors++; if (res !== e.res || hi !== e.hi || lo !== e.lo || dbz !== e.dbz) begin
            miscompares++; $display("FAIL divu_result got %h hi=%h lo=%h dbz=%b want %h %h %h %b", res, hi, lo, dbz, e.res, e.hi, e.lo, e.dbz); end
        m_lo = 32'hFFFFFFFF; m_hi = 32'd9; m_dbz = 1'b1;
        push_exp("divu0", 32'hFFFFFFFF, 0);
        drive_start(4'b0110, 32'd9, 32'd0, 5'd0);
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        vectors++; if (cyc != e.lat || bc != 0) begin miscompares++; $display("FAIL divu0_latency got %0d busy %0d want %0d 0", cyc, bc, e.lat); end
        vectors++; if (res !== e.res || hi !== e.hi || lo !== e.lo || dbz !== e.dbz || zero !== 1'b0) begin
            miscompares++; $display("FAIL divu0_result got %h hi=%h lo=%h dbz=%b z=%b want %h %h %h %b 0", res, hi, lo, dbz, zero, e.res, e.hi, e.lo, e.dbz); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc, bc;
        m_hi = 32'h0; m_lo = 32'd12;
        push_exp("b2b_multu", 32'd12, 32);
        drive_start(4'b0101, 32'd3, 32'd4, 5'd0);
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        vectors++; if (res !== e.res || lo !== e.lo || cyc != e.lat) begin
            miscompares++; $display("FAIL b2b_multu got %h lat %0d want %h lat %0d", res, cyc, e.res, e.lat); end
        push_exp("b2b_add", 32'd5, 0);
        drive_start(4'b0011, 32'd2, 32'd3, 5'd0);
        e = sb.pop_front();
        vectors++; if (done !== 1'b1 || res !== e.res || hi !== e.hi || lo !== e.lo) begin
            miscompares++; $display("FAIL b2b_add got done=%b res=%h lo=%h want 1 %h %h", done, res, lo, e.res, e.lo); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_pulse got %b want 0", done); end
    endtask

    task automatic test_abort();
        int pulses;
        drive_start(4'b0110, 32'd1000, 32'd3, 5'd0);
        repeat (11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        vectors++; if (res !== 32'h0 || hi !== m_hi || lo !== m_lo || zero !== 1'b1) begin
            miscompares++; $display("FAIL abort_outputs got res=%h hi=%h lo=%h z=%b want 0 0 0 1", res, hi, lo, zero); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== m_dbz) begin
            miscompares++; $display("FAIL abort_flags got busy=%b done=%b dbz=%b want 0 0 0", busy, done, dbz); end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
    endtask

    task automatic test_width8();
        logic [15:0] p;
        exp_t        e;
        int          cyc, bc;
        p = 16'd200 * 16'd3;
        e.name = "w8_multu"; e.res = {24'h0, p[7:0]}; e.hi = {24'h0, p[15:8]};
        e.lo = {24'h0, p[7:0]}; e.dbz = 1'b0; e.lat = 8;
        sb.push_back(e);
        start8 = 1'b1; op8 = 4'b0101; a8 = 8'd200; b8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0; bc = 0;
        while (done8 !== 1'b1 && cyc < 100) begin
            if (busy8 === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        vectors++; if (cyc != e.lat || bc != 8) begin miscompares++; $display("FAIL w8_latency got %0d busy %0d want %0d 8", cyc, bc, e.lat); end
        vectors++; if ({24'h0, hi8} !== e.hi || {24'h0, lo8} !== e.lo || {24'h0, res8} !== e.res) begin
            miscompares++; $display("FAIL w8_result got hi=%h lo=%h res=%h want %h %h %h", hi8, lo8, res8, e.hi[7:0], e.lo[7:0], e.res[7:0]); end
        vectors++; if (hi8 !== 8'h02 || lo8 !== 8'h58) begin
            miscompares++; $display("FAIL w8_const got %h/%h want 02/58", hi8, lo8); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multu();
        test_divu();
        test_back_to_back();
        test_abort();
        test_width8();
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_empty got %0d left want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor of the processor's combinational ALU. Keeps the existing ALUOperation encodings and adds arithmetic shift, set-less-than, and iterative unsigned multiply and divide that write HI/LO. The block has a start/done handshake, so the datapath controller can stall on multi-cycle operations. It sits in the execute stage, fed by the ALU control decoder.

## Interface
Parameters:
- WIDTH, 32: operand and result width; must be at least 4.
- SHAMT_W, $clog2(WIDTH): shift-amount width (5 at WIDTH = 32).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only when the block is not busy.
- ALUOperation  in  4  operation code, sampled with start.
- A  in  WIDTH  operand; sampled with start.
- B  in  WIDTH  operand; sampled with start.
- shamt  in  SHAMT_W  shift amount; sampled with start.
- busy  out  1  a multiply or divide is iterating.
- done  out  1  one-cycle completion pulse.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  high when ALUResult == 0.
- HI  out  WIDTH  multiply high word or divide remainder.
- LO  out  WIDTH  multiply low word or divide quotient.
- DivByZero  out  1  the last DIVU had B == 0.

## Operation
Operation codes; existing codes are unchanged:
- AND 0000, OR 0001, NOR 0010, ADD 0011 (wraps mod 2^WIDTH), SUB 0100 (wraps).
- SLL 1110 and SRL 1100 shift B by shamt. JR 1101 returns A[25:21] zero-extended.
- New: SRA 1111 (B >>> shamt, sign-filled), SLT 0111 (signed A < B gives 1, else 0), SLTU 1000 (unsigned compare).
- New: MULTU 0101 and DIVU 0110. Every other code returns a result of 0.

State machine with states IDLE and RUN:
- In IDLE, start with a single-cycle op: the result registers on that edge and done is asserted for the next cycle; the state stays IDLE.
- In IDLE, start with MULTU: load A, B and counter = 0, then go to RUN. Each RUN cycle performs one shift-add step into a 2·WIDTH-bit accumulator.
- In IDLE, start with DIVU and B ≠ 0: one restoring subtract-shift step per RUN cycle.
- RUN returns to IDLE on the edge that completes iteration WIDTH−1. On that same edge HI/LO load, ALUResult = LO, and done is asserted.
- DIVU with B == 0 does not enter RUN; it finishes like a single-cycle op with HI = A, LO = all ones, ALUResult = all ones and DivByZero = 1.
- DivByZero is updated only by DIVU completions. HI and LO change only on MULTU/DIVU completion.
- Zero is registered together with ALUResult.

## Timing
Reset values (immediate, asynchronous):
- State IDLE, counter 0.
- busy, done, DivByZero = 0.
- ALUResult, HI, LO = 0.
- Zero = 1.

Latency:
- Single-cycle ops: done is high during the cycle after the start edge.
- MULTU/DIVU: busy is high for WIDTH cycles starting the cycle after the start edge. done is high in the cycle after the last iteration edge, so WIDTH edges after start; busy is already low in that cycle.

Handshake rules:
- start while busy is ignored; the operand registers and the operation are not disturbed.
- start in the same cycle that done is high is accepted, giving back-to-back issue.
- Outputs hold their value until the next completion; done never lasts more than one cycle.
- Reset asserted mid-RUN aborts the operation. No done is produced and all outputs return to reset values.

## Structure
- A shared package `alu_pkg` holds:
  - the 4-bit opcode localparams;
  - the state encoding (IDLE, RUN).
- One sub-module, `alu_muldiv_iter`, is natural. It contains:
  - the accumulator and iteration counter;
  - the shift-add and restoring-divide step;
  - its own load and last-iteration strobes.
- The top level holds the combinational single-cycle ops, the FSM and the output registers.

## Test plan
- Reset: assert reset asynchronously between edges. ALUResult = HI = LO = 0 and Zero = 1 immediately; busy = done = 0.
- Single-cycle ops, WIDTH = 32:
  - ADD 0x7FFFFFFF + 1 gives 0x80000000, done on the next cycle.
  - SUB 5 − 5 gives 0 with Zero = 1.
  - SRA 0x80000000 by 4 gives 0xF8000000.
  - SLT −1 < 1 gives 1; SLTU of the same operands gives 0.
  - Unused code 1001 gives 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy for 32 cycles, then done.
  - HI = 0xFFFFFFFE, LO = 0x00000001, ALUResult = 1.
  - A start pulsed mid-run is ignored.
- DIVU:
  - 100 / 7 gives LO = 14, HI = 2, DivByZero = 0 after 32 cycles.
  - Then 9 / 0 gives done after 1 cycle with LO = 0xFFFFFFFF, HI = 9, DivByZero = 1.
- Back-to-back and abort:
  - A start of ADD 2+3 in the cycle that MULTU's done is high gives 5 one cycle later.
  - Reset at iteration 10 of a DIVU produces no done pulse and returns all outputs to reset values.
- Parametric run at WIDTH = 8: MULTU 200 × 3 gives HI = 0x02, LO = 0x58 after 8 busy cycles.
